// File: rtl/dist_history.sv
// Distance sample history: captures samples into a circular buffer and keeps
// a running window sum/average plus indexed readback (index 0 = newest).
module dist_history #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int EDGE_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       opt,
  input  logic [WIDTH-1:0]           dis,
  input  logic                       clear,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [WIDTH-1:0]           save_data,
  output logic                       new_pulse,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic [WIDTH-1:0]           avg,
  output logic                       avg_valid,
  output logic [WIDTH-1:0]           rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = WIDTH + AW;

  logic              opt_d_reg,     opt_d_next;
  logic [AW-1:0]     wr_ptr_reg,    wr_ptr_next;
  logic [AW:0]       count_reg,     count_next;
  logic              full_reg,      full_next;
  logic [SW-1:0]     sum_reg,       sum_next;
  logic [WIDTH-1:0]  avg_reg,       avg_next;
  logic              avg_valid_reg, avg_valid_next;
  logic [WIDTH-1:0]  save_data_reg, save_data_next;
  logic              new_pulse_reg, new_pulse_next;
  logic [WIDTH-1:0]  rd_data_reg,   rd_data_next;

  logic              cap;
  logic              wr_en;
  logic [AW-1:0]     rd_addr;
  logic              rd_hit;
  logic [WIDTH-1:0]  oldest;
  logic [WIDTH-1:0]  mem [DEPTH];

  generate
    if (EDGE_MODE != 0) begin : g_edge
      assign cap = opt & ~opt_d_reg;
    end else begin : g_level
      assign cap = opt;
    end
  endgenerate

  // A dropped sample on clear must not touch the buffer either.
  assign wr_en = cap & ~clear;

  // Storage has no reset: count gates every read, so stale contents are
  // never observable after reset or clear.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= dis;
        end
      end
      assign mem[gi] = entry_reg;
    end
  endgenerate

  // wr_ptr - 1 - rd_idx wraps naturally in AW bits; -1-x equals ~x.
  assign rd_addr = wr_ptr_reg + ~rd_idx;
  assign rd_hit  = ({1'b0, rd_idx} < count_reg);
  assign oldest  = mem[wr_ptr_reg];

  always_comb begin
    opt_d_next     = opt;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    full_next      = full_reg;
    sum_next       = sum_reg;
    avg_next       = sum_reg[SW-1:AW];
    avg_valid_next = full_reg;
    save_data_next = save_data_reg;
    new_pulse_next = 1'b0;
    rd_data_next   = rd_hit ? mem[rd_addr] : '0;

    if (clear) begin
      wr_ptr_next    = '0;
      count_next     = '0;
      full_next      = 1'b0;
      sum_next       = '0;
      avg_next       = '0;
      avg_valid_next = 1'b0;
    end else if (cap) begin
      wr_ptr_next    = wr_ptr_reg + 1'b1;
      save_data_next = dis;
      new_pulse_next = 1'b1;
      if (full_reg) begin
        // Oldest entry leaves the window as the new one enters.
        sum_next = sum_reg + {{AW{1'b0}}, dis} - {{AW{1'b0}}, oldest};
      end else begin
        sum_next   = sum_reg + {{AW{1'b0}}, dis};
        count_next = count_reg + 1'b1;
        full_next  = (count_reg == (AW+1)'(DEPTH - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opt_d_reg     <= 1'b0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      sum_reg       <= '0;
      avg_reg       <= '0;
      avg_valid_reg <= 1'b0;
      save_data_reg <= '0;
      new_pulse_reg <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      opt_d_reg     <= opt_d_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      full_reg      <= full_next;
      sum_reg       <= sum_next;
      avg_reg       <= avg_next;
      avg_valid_reg <= avg_valid_next;
      save_data_reg <= save_data_next;
      new_pulse_reg <= new_pulse_next;
      rd_data_reg   <= rd_data_next;
    end
  end

  assign save_data = save_data_reg;
  assign new_pulse = new_pulse_reg;
  assign count     = count_reg;
  assign full      = full_reg;
  assign avg       = avg_reg;
  assign avg_valid = avg_valid_reg;
  assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_dist_history.sv
// Directed bench for dist_history: edge-mode instance u0 and level-mode
// instance u1 share clock, reset, dis, clear and rd_idx.
module tb_dist_history;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        opt, opt1;
  logic [15:0] dis;
  logic        clear;
  logic [2:0]  rd_idx;

  logic [15:0] save_data, avg, rd_data;
  logic        new_pulse, full, avg_valid;
  logic [3:0]  count;

  logic [15:0] save_data1, avg1, rd_data1;
  logic        new_pulse1, full1, avg_valid1;
  logic [3:0]  count1;

  int vectors = 0;
  int errors  = 0;
  int pulses;

  always #5 clk = ~clk;

  dist_history #(.WIDTH(16), .DEPTH(8), .EDGE_MODE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .opt(opt), .dis(dis), .clear(clear),
    .rd_idx(rd_idx), .save_data(save_data), .new_pulse(new_pulse),
    .count(count), .full(full), .avg(avg), .avg_valid(avg_valid),
    .rd_data(rd_data)
  );

  dist_history #(.WIDTH(16), .DEPTH(8), .EDGE_MODE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .opt(opt1), .dis(dis), .clear(clear),
    .rd_idx(rd_idx), .save_data(save_data1), .new_pulse(new_pulse1),
    .count(count1), .full(full1), .avg(avg1), .avg_valid(avg_valid1),
    .rd_data(rd_data1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opt = 1'b0; opt1 = 1'b0; dis = '0; clear = 1'b0; rd_idx = '0;
    #2;
    check("reset count", 32'(count), 0);
    check("reset save_data", 32'(save_data), 0);
    check("reset avg_valid", 32'(avg_valid), 0);
    tick();
    rst_n = 1'b1;

    // Eight pulsed captures 10..80
    for (int k = 1; k <= 8; k++) begin
      opt = 1'b1; dis = 16'(10 * k);
      tick();
      $display("capture dis=%0d count=%0d full=%0d", 10 * k, count, full);
      check("cap new_pulse", 32'(new_pulse), 1);
      check("cap count", 32'(count), 32'(k));
      check("cap full", 32'(full), (k == 8) ? 1 : 0);
      if (k == 8) check("avg_valid lags full", 32'(avg_valid), 0);
      opt = 1'b0;
      tick();
      check("pulse one cycle", 32'(new_pulse), 0);
    end
    check("avg 10..80", 32'(avg), 45);
    check("avg_valid full", 32'(avg_valid), 1);
    check("save_data 80", 32'(save_data), 80);

    // Ninth capture displaces the oldest sample
    opt = 1'b1; dis = 16'd170;
    tick();
    opt = 1'b0;
    tick();
    $display("capture dis=170 avg=%0d", avg);
    check("avg after wrap", 32'(avg), 65);
    check("count saturates", 32'(count), 8);
    rd_idx = 3'd0;
    tick();
    check("rd_idx0", 32'(rd_data), 170);
    rd_idx = 3'd7;
    tick();
    check("rd_idx7", 32'(rd_data), 20);

    // Held opt: one capture only
    pulses = 0;
    opt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      dis = 16'(100 + i);
      tick();
      if (new_pulse) pulses++;
    end
    opt = 1'b0;
    tick();
    if (new_pulse) pulses++;
    $display("held opt pulses=%0d save_data=%0d", pulses, save_data);
    check("held pulses", 32'(pulses), 1);
    check("held save_data", 32'(save_data), 100);
    check("held avg", 32'(avg), 75);

    // Clear together with opt on a full buffer
    clear = 1'b1; opt = 1'b1; dis = 16'd999;
    tick();
    $display("clear count=%0d save_data=%0d", count, save_data);
    check("clear count", 32'(count), 0);
    check("clear full", 32'(full), 0);
    check("clear avg_valid", 32'(avg_valid), 0);
    check("clear new_pulse", 32'(new_pulse), 0);
    check("clear avg", 32'(avg), 0);
    check("clear save_data", 32'(save_data), 100);
    clear = 1'b0; rd_idx = 3'd0;
    tick();
    check("held after clear", 32'(count), 0);
    check("clear rd_data", 32'(rd_data), 0);
    opt = 1'b0;
    tick();

    // Mid-cycle asynchronous reset with five entries
    for (int k = 1; k <= 5; k++) begin
      opt = 1'b1; dis = 16'(k);
      tick();
      opt = 1'b0;
      tick();
    end
    check("pre-reset count", 32'(count), 5);
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset count=%0d rd_data=%0d", count, rd_data);
    check("async count", 32'(count), 0);
    check("async save_data", 32'(save_data), 0);
    check("async avg", 32'(avg), 0);
    check("async rd_data", 32'(rd_data), 0);
    check("async full", 32'(full | avg_valid | new_pulse), 0);
    #2;
    rst_n = 1'b1; opt = 1'b1; dis = 16'd77; rd_idx = 3'd0;
    tick();
    check("post-reset count", 32'(count), 1);
    check("post-reset pulse", 32'(new_pulse), 1);
    opt = 1'b0;
    tick();
    check("post-reset rd0", 32'(rd_data), 77);

    // Level mode: three back-to-back captures
    opt1 = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      dis = 16'(k);
      tick();
    end
    opt1 = 1'b0;
    $display("level mode count=%0d", count1);
    check("level count", 32'(count1), 3);
    check("level save_data", 32'(save_data1), 3);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 3'(i);
      tick();
      check("level rd", 32'(rd_data1), (i < 3) ? 32'(3 - i) : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dist_history.md
DIST_HISTORY -- requirements
Module: dist_history

Interface
REQ-001 Parameter WIDTH, default 16, bit width of one distance sample.
REQ-002 Parameter DEPTH, default 8, history depth in samples; legal values are powers of two from 2 to 256.
REQ-003 Parameter EDGE_MODE, default 1: 1 = capture on rising edge of opt; 0 = capture on every cycle opt is high.
REQ-004 Ports SHALL be:
- clk  input  1  sole clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- opt  input  1  capture request.
- dis  input  WIDTH  distance sample to capture.
- clear  input  1  synchronous history flush.
- rd_idx  input  log2(DEPTH)  readback index; 0 = newest sample.
- save_data  output  WIDTH  most recently captured sample.
- new_pulse  output  1  one-cycle strobe per capture.
- count  output  log2(DEPTH)+1  number of valid entries, saturating at DEPTH.
- full  output  1  count == DEPTH.
- avg  output  WIDTH  window average.
- avg_valid  output  1  avg is meaningful.
- rd_data  output  WIDTH  history entry selected by rd_idx.

Function
REQ-005 Capture event cap SHALL be (opt & ~opt_d) when EDGE_MODE=1, where opt_d is opt registered one cycle; cap SHALL be opt when EDGE_MODE=0.
REQ-006 On cap, dis SHALL be written to mem[wr_ptr], save_data SHALL load dis, and new_pulse SHALL be 1; all three take effect on the same edge, so they are visible one cycle after the sampling edge.
REQ-007 wr_ptr SHALL increment modulo DEPTH on each cap, wrapping from DEPTH-1 to 0.
REQ-008 count SHALL increment on each cap while count < DEPTH, and SHALL hold at DEPTH thereafter.
REQ-009 A running sum of width WIDTH+log2(DEPTH) SHALL update on cap as follows:
- if not full: sum + dis.
- if full: sum + dis - mem[wr_ptr], where mem[wr_ptr] is the oldest entry, read before it is overwritten.
- The sum SHALL never overflow.
REQ-010 avg SHALL equal sum >> log2(DEPTH) and SHALL be registered, updating one cycle after the sum changes.
REQ-011 avg_valid SHALL be 1 only while full=1, so avg_valid and avg are aligned.
REQ-012 rd_data SHALL be registered.
- rd_data = mem[(wr_ptr-1-rd_idx) mod DEPTH], with one-cycle latency from rd_idx.
- If rd_idx >= count, rd_data SHALL be 0.
REQ-013 When clear=1, wr_ptr, count, sum and avg SHALL go to 0, and full, avg_valid and new_pulse SHALL go to 0. save_data SHALL retain its value; mem contents need not be cleared.
REQ-014 clear and cap in the same cycle: clear SHALL win and the sample SHALL be dropped. opt_d SHALL still update, so a held opt does not re-capture in EDGE_MODE=1.
REQ-015 While opt is held high in EDGE_MODE=1, exactly one capture SHALL occur per assertion.
REQ-016 In EDGE_MODE=0, back-to-back captures every cycle SHALL be supported with no lost samples.

Reset
REQ-017 When rst_n=0, all registers SHALL be forced immediately, independent of clk:
- save_data, rd_data, avg, sum, count, wr_ptr = 0.
- new_pulse, full, avg_valid = 0.
- opt_d = 0.
REQ-018 After release of rst_n, if opt is already high on the first edge, it SHALL count as a rising edge in EDGE_MODE=1.
REQ-019 Reset asserted mid-operation SHALL discard all history. The first capture after reset SHALL behave as on an empty buffer.

Verification
REQ-020 Edge mode, default parameters: pulse opt with dis = 10, 20, ..., 80 (8 captures). Required:
- count goes 1..8; full=1 after the 8th.
- avg = 45 and avg_valid=1 one cycle after full.
- save_data = 80.
REQ-021 Continue with a 9th capture, dis = 170. Required:
- sum drops 10 and adds 170, so avg = 65.
- rd_idx=0 gives rd_data = 170; rd_idx=7 gives rd_data = 20.
REQ-022 Edge mode: hold opt high for 5 cycles with dis changing each cycle. Required: exactly one capture of the first-cycle dis, and one new_pulse.
REQ-023 EDGE_MODE=0: opt high for 3 consecutive cycles with dis = 1, 2, 3. Required: count = 3, and rd_idx = 0, 1, 2 gives 3, 2, 1.
REQ-024 Assert clear together with opt on a full buffer. Required:
- count=0, avg_valid=0, new_pulse=0.
- save_data unchanged.
- rd_idx=0 gives rd_data = 0.
REQ-025 Drop rst_n asynchronously between clock edges while count=5. Required:
- All outputs are 0 before the next edge.
- The first capture afterwards gives count=1 and rd_data(0) = the captured dis.
